// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Initiator side of the datapath ALU. Decodes one RV32I ALU or
//               branch instruction, drives the combinational ALU, samples its
//               result after ALU_WAIT cycles and returns result/taken/illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction request
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    // combinational ALU
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    // response
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_taken,
    output logic        out_is_branch,
    output logic        out_illegal
);

    localparam logic [6:0] C_OPC_R   = 7'b0110011;
    localparam logic [6:0] C_OPC_I   = 7'b0010011;
    localparam logic [6:0] C_OPC_B   = 7'b1100011;
    localparam logic [6:0] C_F7_BASE = 7'b0000000;
    localparam logic [6:0] C_F7_ALT  = 7'b0100000;

    localparam logic [3:0] C_OP_ADD  = 4'd0;
    localparam logic [3:0] C_OP_SUB  = 4'd1;
    localparam logic [3:0] C_OP_AND  = 4'd2;
    localparam logic [3:0] C_OP_OR   = 4'd3;
    localparam logic [3:0] C_OP_XOR  = 4'd4;
    localparam logic [3:0] C_OP_SLL  = 4'd5;
    localparam logic [3:0] C_OP_SRL  = 4'd6;
    localparam logic [3:0] C_OP_SRA  = 4'd7;
    localparam logic [3:0] C_OP_SLT  = 4'd8;
    localparam logic [3:0] C_OP_SLTU = 4'd9;

    // Branch condition select: bit1 picks result[0] over zero, bit0 inverts.
    localparam logic [1:0] C_BR_ZERO  = 2'b00;
    localparam logic [1:0] C_BR_NZERO = 2'b01;
    localparam logic [1:0] C_BR_LT    = 2'b10;
    localparam logic [1:0] C_BR_GE    = 2'b11;

    localparam logic [1:0] C_CNT_INIT = 2'(ALU_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state_q;
    state_t      w_state_d;
    logic [1:0]  r_cnt_q;
    logic [31:0] r_alu_a_q;
    logic [31:0] r_alu_b_q;
    logic [3:0]  r_alu_op_q;
    logic [1:0]  r_br_sel_q;
    logic [31:0] r_result_q;
    logic        r_taken_q;
    logic        r_is_branch_q;
    logic        r_illegal_q;

    logic        w_legal;
    logic        w_is_br;
    logic [3:0]  w_op;
    logic [31:0] w_b;
    logic [1:0]  w_br_sel;
    logic        w_accept;
    logic        w_sample;
    logic        w_release;
    logic        w_cond;

    // funct3 to ALU op for R-type and I-type; alt selects SUB/SRA.
    function automatic logic [3:0] f3_to_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? C_OP_SUB : C_OP_ADD;
            3'b001:  op = C_OP_SLL;
            3'b010:  op = C_OP_SLT;
            3'b011:  op = C_OP_SLTU;
            3'b100:  op = C_OP_XOR;
            3'b101:  op = alt ? C_OP_SRA : C_OP_SRL;
            3'b110:  op = C_OP_OR;
            default: op = C_OP_AND;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_legal  = 1'b0;
        w_is_br  = 1'b0;
        w_op     = C_OP_ADD;
        w_b      = in_rs2;
        w_br_sel = C_BR_ZERO;
        case (in_opcode)
            C_OPC_R: begin
                if (in_funct7 == C_F7_BASE) begin
                    w_legal = 1'b1;
                    w_op    = f3_to_op(in_funct3, 1'b0);
                end else if ((in_funct7 == C_F7_ALT) &&
                             ((in_funct3 == 3'b000) || (in_funct3 == 3'b101))) begin
                    w_legal = 1'b1;
                    w_op    = f3_to_op(in_funct3, 1'b1);
                end
            end
            C_OPC_I: begin
                w_b = in_imm;
                case (in_funct3)
                    3'b001: begin
                        w_legal = (in_funct7 == C_F7_BASE);
                        w_op    = C_OP_SLL;
                    end
                    3'b101: begin
                        w_legal = (in_funct7 == C_F7_BASE) || (in_funct7 == C_F7_ALT);
                        w_op    = (in_funct7 == C_F7_ALT) ? C_OP_SRA : C_OP_SRL;
                    end
                    default: begin
                        // funct7 is part of the immediate for non-shift ops
                        w_legal = 1'b1;
                        w_op    = f3_to_op(in_funct3, 1'b0);
                    end
                endcase
            end
            C_OPC_B: begin
                w_is_br = 1'b1;
                case (in_funct3)
                    3'b000: begin w_legal = 1'b1; w_op = C_OP_SUB;  w_br_sel = C_BR_ZERO;  end
                    3'b001: begin w_legal = 1'b1; w_op = C_OP_SUB;  w_br_sel = C_BR_NZERO; end
                    3'b100: begin w_legal = 1'b1; w_op = C_OP_SLT;  w_br_sel = C_BR_LT;    end
                    3'b101: begin w_legal = 1'b1; w_op = C_OP_SLT;  w_br_sel = C_BR_GE;    end
                    3'b110: begin w_legal = 1'b1; w_op = C_OP_SLTU; w_br_sel = C_BR_LT;    end
                    3'b111: begin w_legal = 1'b1; w_op = C_OP_SLTU; w_br_sel = C_BR_GE;    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_accept  = 1'b0;
        w_sample  = 1'b0;
        w_release = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept  = 1'b1;
                    w_state_d = w_legal ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                if (r_cnt_q == 2'd0) begin
                    w_sample  = 1'b1;
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign w_cond = (r_br_sel_q[1] ? alu_result[0] : alu_zero) ^ r_br_sel_q[0];

    // ------------------------------------------------------------------
    // Operand, counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_q       <= 2'd0;
            r_alu_a_q     <= 32'd0;
            r_alu_b_q     <= 32'd0;
            r_alu_op_q    <= 4'd0;
            r_br_sel_q    <= C_BR_ZERO;
            r_result_q    <= 32'd0;
            r_taken_q     <= 1'b0;
            r_is_branch_q <= 1'b0;
            r_illegal_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt_q       <= C_CNT_INIT;
                r_br_sel_q    <= w_br_sel;
                r_result_q    <= 32'd0;
                r_taken_q     <= 1'b0;
                r_is_branch_q <= w_legal & w_is_br;
                r_illegal_q   <= ~w_legal;
                // Illegal encodings never reach the ALU; its inputs stay at 0.
                if (w_legal) begin
                    r_alu_a_q  <= in_rs1;
                    r_alu_b_q  <= w_b;
                    r_alu_op_q <= w_op;
                end
            end else if (r_state_q == ST_EXEC) begin
                if (w_sample) begin
                    r_result_q <= alu_result;
                    r_taken_q  <= r_is_branch_q & w_cond;
                end else begin
                    r_cnt_q <= r_cnt_q - 2'd1;
                end
            end
            if (w_release) begin
                r_alu_a_q  <= 32'd0;
                r_alu_b_q  <= 32'd0;
                r_alu_op_q <= 4'd0;
            end
        end
    end

    assign in_ready      = (r_state_q == ST_IDLE);
    assign out_valid     = (r_state_q == ST_DONE);
    assign alu_a         = r_alu_a_q;
    assign alu_b         = r_alu_b_q;
    assign alu_op        = r_alu_op_q;
    assign out_result    = r_result_q;
    assign out_taken     = r_taken_q;
    assign out_is_branch = r_is_branch_q;
    assign out_illegal   = r_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench; two sequencers (ALU_WAIT 1 and 3) each
//               driving a behavioural ALU, checked against an ISA-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    typedef struct packed {
        logic        legal;
        logic        is_br;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        taken;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid      [2];
    logic        in_ready      [2];
    logic [6:0]  in_opcode     [2];
    logic [2:0]  in_funct3     [2];
    logic [6:0]  in_funct7     [2];
    logic [31:0] in_rs1        [2];
    logic [31:0] in_rs2        [2];
    logic [31:0] in_imm        [2];
    logic [31:0] alu_a         [2];
    logic [31:0] alu_b         [2];
    logic [3:0]  alu_op        [2];
    logic [31:0] alu_result    [2];
    logic        alu_zero      [2];
    logic        out_valid     [2];
    logic        out_ready     [2];
    logic [31:0] out_result    [2];
    logic        out_taken     [2];
    logic        out_is_branch [2];
    logic        out_illegal   [2];

    int   n_pass;
    int   n_total;
    logic chk_en;
    int   m_state [2];
    int   m_cnt   [2];
    exp_t m_exp   [2];

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Behavioural combinational ALU
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return {31'd0, $signed(a) < $signed(b)};
            4'd9:    return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    // ISA-level expectation for one instruction
    function automatic exp_t ref_model(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [6:0] f7, input logic [31:0] rs1,
                                       input logic [31:0] rs2, input logic [31:0] imm);
        exp_t e;
        logic [3:0] tbl [8];
        logic alt;
        tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        alt = (f7 == 7'h20);
        e = '0;
        e.a = rs1;
        if (opc == 7'h33) begin
            e.b     = rs2;
            e.legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
            e.op    = tbl[f3];
            if (alt && f3 == 3'd0) e.op = 4'd1;
            if (alt && f3 == 3'd5) e.op = 4'd7;
        end else if (opc == 7'h13) begin
            e.b = imm;
            if (f3 == 3'd1)      e.legal = (f7 == 7'h00);
            else if (f3 == 3'd5) e.legal = (f7 == 7'h00) || alt;
            else                 e.legal = 1'b1;
            e.op = tbl[f3];
            if (alt && f3 == 3'd5) e.op = 4'd7;
        end else if (opc == 7'h63) begin
            e.b     = rs2;
            e.is_br = 1'b1;
            e.legal = 1'b1;
            case (f3)
                3'd0: begin e.op = 4'd1; e.taken = (rs1 == rs2); end
                3'd1: begin e.op = 4'd1; e.taken = (rs1 != rs2); end
                3'd4: begin e.op = 4'd8; e.taken = ($signed(rs1) <  $signed(rs2)); end
                3'd5: begin e.op = 4'd8; e.taken = ($signed(rs1) >= $signed(rs2)); end
                3'd6: begin e.op = 4'd9; e.taken = (rs1 <  rs2); end
                3'd7: begin e.op = 4'd9; e.taken = (rs1 >= rs2); end
                default: e.legal = 1'b0;
            endcase
        end
        if (!e.legal) begin
            e = '0;
        end else begin
            e.result = alu_fn(e.op, rs1, e.b);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    for (genvar i = 0; i < 2; i++) begin : g_dut
        alu_op_sequencer #(.ALU_WAIT(i == 0 ? 1 : 3)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid      (in_valid[i]),
            .in_ready      (in_ready[i]),
            .in_opcode     (in_opcode[i]),
            .in_funct3     (in_funct3[i]),
            .in_funct7     (in_funct7[i]),
            .in_rs1        (in_rs1[i]),
            .in_rs2        (in_rs2[i]),
            .in_imm        (in_imm[i]),
            .alu_a         (alu_a[i]),
            .alu_b         (alu_b[i]),
            .alu_op        (alu_op[i]),
            .alu_result    (alu_result[i]),
            .alu_zero      (alu_zero[i]),
            .out_valid     (out_valid[i]),
            .out_ready     (out_ready[i]),
            .out_result    (out_result[i]),
            .out_taken     (out_taken[i]),
            .out_is_branch (out_is_branch[i]),
            .out_illegal   (out_illegal[i])
        );
        assign alu_result[i] = alu_fn(alu_op[i], alu_a[i], alu_b[i]);
        assign alu_zero[i]   = (alu_result[i] == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: 0 idle, 1 executing, 2 response pending
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (chk_en) begin
                chk($sformatf("in_ready[%0d]", k),  {31'd0, in_ready[k]},  {31'd0, m_state[k] == 0});
                chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]}, {31'd0, m_state[k] == 2});
                if (m_state[k] == 0) begin
                    chk($sformatf("idle_alu_op[%0d]", k), {28'd0, alu_op[k]}, 32'd0);
                    chk($sformatf("idle_alu_a[%0d]", k), alu_a[k], 32'd0);
                    chk($sformatf("idle_alu_b[%0d]", k), alu_b[k], 32'd0);
                end else begin
                    chk($sformatf("alu_op[%0d]", k), {28'd0, alu_op[k]}, {28'd0, m_exp[k].op});
                    chk($sformatf("alu_a[%0d]", k), alu_a[k], m_exp[k].a);
                    chk($sformatf("alu_b[%0d]", k), alu_b[k], m_exp[k].b);
                end
                if (m_state[k] == 2) begin
                    chk($sformatf("out_result[%0d]", k), out_result[k], m_exp[k].result);
                    chk($sformatf("out_taken[%0d]", k), {31'd0, out_taken[k]}, {31'd0, m_exp[k].taken});
                    chk($sformatf("out_is_branch[%0d]", k), {31'd0, out_is_branch[k]}, {31'd0, m_exp[k].is_br});
                    chk($sformatf("out_illegal[%0d]", k), {31'd0, out_illegal[k]}, {31'd0, !m_exp[k].legal});
                end
            end
            if (rst_n !== 1'b1) begin
                m_state[k] = 0;
            end else if (m_state[k] == 0) begin
                if (in_valid[k]) begin
                    m_exp[k] = ref_model(in_opcode[k], in_funct3[k], in_funct7[k],
                                         in_rs1[k], in_rs2[k], in_imm[k]);
                    m_state[k] = m_exp[k].legal ? 1 : 2;
                    m_cnt[k]   = wait_of(k);
                end
            end else if (m_state[k] == 1) begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) m_state[k] = 2;
            end else if (out_ready[k]) begin
                m_state[k] = 0;
            end
        end
    end

    // Issue one instruction, check literal expectations, then consume after `hold` stall cycles
    task automatic issue(input int k, input string nm, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input int hold,
                         input logic [3:0] x_op, input logic [31:0] x_b,
                         input logic [31:0] x_res, input logic x_taken, input logic x_ill);
        int lat;
        chk({nm, "_ready_before"}, {31'd0, in_ready[k]}, 32'd1);
        in_opcode[k] = opc; in_funct3[k] = f3; in_funct7[k] = f7;
        in_rs1[k] = rs1; in_rs2[k] = rs2; in_imm[k] = imm;
        in_valid[k] = 1'b1;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        chk({nm, "_alu_op"}, {28'd0, alu_op[k]}, {28'd0, x_op});
        chk({nm, "_alu_b"}, alu_b[k], x_b);
        lat = 1;
        while (!out_valid[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, x_ill ? 32'd1 : 32'(wait_of(k) + 1));
        chk({nm, "_result"}, out_result[k], x_res);
        chk({nm, "_taken"}, {31'd0, out_taken[k]}, {31'd0, x_taken});
        chk({nm, "_illegal"}, {31'd0, out_illegal[k]}, {31'd0, x_ill});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, {31'd0, out_valid[k]}, 32'd1);
            chk({nm, "_hold_ready"}, {31'd0, in_ready[k]}, 32'd0);
            chk({nm, "_hold_result"}, out_result[k], x_res);
        end
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        chk({nm, "_ready_after"}, {31'd0, in_ready[k]}, 32'd1);
        chk({nm, "_valid_after"}, {31'd0, out_valid[k]}, 32'd0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        m_state = '{0, 0}; m_cnt = '{0, 0}; m_exp = '{'0, '0};
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b0;
            in_opcode[k] = '0; in_funct3[k] = '0; in_funct7[k] = '0;
            in_rs1[k] = '0; in_rs2[k] = '0; in_imm[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_out_valid", {31'd0, out_valid[k]}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready[k]}, 32'd1);
            chk("rst_out_result", out_result[k], 32'd0);
            chk("rst_alu_op", {28'd0, alu_op[k]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        //       k  name     opc    f3    f7     rs1           rs2           imm           hold op  b             result        tk ill
        issue(0, "sub",   7'h33, 3'd0, 7'h20, 32'h5,        32'h7,        32'h0,        0, 4'd1, 32'h7,        32'hFFFFFFFE, 0, 0);
        issue(0, "blt",   7'h63, 3'd4, 7'h00, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 4'd8, 32'h1,        32'h1,        1, 0);
        issue(0, "bltu",  7'h63, 3'd6, 7'h00, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 4'd9, 32'h1,        32'h0,        0, 0);
        issue(0, "beq",   7'h63, 3'd0, 7'h00, 32'h1234,     32'h1234,     32'h0,        0, 4'd1, 32'h1234,     32'h0,        1, 0);
        issue(0, "bne",   7'h63, 3'd1, 7'h00, 32'h1234,     32'h1234,     32'h0,        1, 4'd1, 32'h1234,     32'h0,        0, 0);
        issue(0, "srai",  7'h13, 3'd5, 7'h20, 32'h80000000, 32'h0,        32'h404,      0, 4'd7, 32'h404,      32'hF8000000, 0, 0);
        issue(0, "ill7f", 7'h7F, 3'd0, 7'h00, 32'h55,       32'h66,       32'h77,       0, 4'd0, 32'h0,        32'h0,        0, 1);
        issue(0, "addi",  7'h13, 3'd0, 7'h55, 32'h10,       32'h0,        32'hFFFFFFFF, 0, 4'd0, 32'hFFFFFFFF, 32'hF,        0, 0);
        issue(0, "bge",   7'h63, 3'd5, 7'h00, 32'h3,        32'h3,        32'h0,        0, 4'd8, 32'h3,        32'h0,        1, 0);
        issue(0, "xor",   7'h33, 3'd4, 7'h00, 32'hF0F0,     32'hFF00,     32'h0,        0, 4'd4, 32'hFF00,     32'h0FF0,     0, 0);
        issue(0, "illmul",7'h33, 3'd0, 7'h01, 32'h2,        32'h3,        32'h0,        0, 4'd0, 32'h0,        32'h0,        0, 1);
        issue(0, "illbr", 7'h63, 3'd2, 7'h00, 32'h2,        32'h3,        32'h0,        0, 4'd0, 32'h0,        32'h0,        0, 1);
        issue(1, "sub3",  7'h33, 3'd0, 7'h20, 32'h64,       32'h1,        32'h0,        5, 4'd1, 32'h1,        32'h63,       0, 0);
        issue(1, "bgeu3", 7'h63, 3'd7, 7'h00, 32'h2,        32'hFFFFFFFF, 32'h0,        0, 4'd9, 32'hFFFFFFFF, 32'h1,        0, 0);

        // Reset while executing: operation must vanish without a response
        in_opcode[1] = 7'h33; in_funct3[1] = 3'd0; in_funct7[1] = 7'h00;
        in_rs1[1] = 32'h9; in_rs2[1] = 32'h1;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        chk("rstexec_in_exec", {31'd0, in_ready[1]}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstexec_ready", {31'd0, in_ready[1]}, 32'd1);
        chk("rstexec_valid", {31'd0, out_valid[1]}, 32'd0);
        chk("rstexec_alu_op", {28'd0, alu_op[1]}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("rstexec_no_resp", {31'd0, out_valid[1]}, 32'd0);
        end

        issue(1, "after", 7'h13, 3'd7, 7'h00, 32'hABCD, 32'h0, 32'hFF, 0, 4'd2, 32'hFF, 32'hCD, 0, 0);
        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the datapath ALU interface.
- Accepts one decoded RV32I instruction per handshake: opcode/funct3/funct7 plus rs1, rs2 and imm values.
- Decodes it to the team's 4-bit ALU operation code, drives operands and op to the combinational ALU, samples Result/Zero after a configurable settle time, and resolves branch outcomes.
- Returns result, taken and illegal flags on an output valid/ready handshake.

Parameters:
- ALU_WAIT, 1, cycles the ALU inputs are held stable before Result/Zero are sampled (legal 1..4).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  instruction fields valid
- in_ready  output  1  sequencer can accept (IDLE only)
- in_opcode  input  7  instr[6:0]
- in_funct3  input  3  instr[14:12]
- in_funct7  input  7  instr[31:25], also for I-type shifts
- in_rs1  input  32  source operand 1
- in_rs2  input  32  source operand 2
- in_imm  input  32  sign-extended immediate
- alu_a  output  32  ALU operand A
- alu_b  output  32  ALU operand B
- alu_op  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
- alu_result  input  32  ALU Result
- alu_zero  input  1  ALU Zero (Result==0)
- out_valid  output  1  response valid
- out_ready  input  1  consumer accepts response
- out_result  output  32  sampled ALU result (0 when illegal)
- out_taken  output  1  branch taken (0 for non-branch)
- out_is_branch  output  1  instruction was a branch
- out_illegal  output  1  unsupported encoding, no ALU op issued

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset: FSM to IDLE; counter 0; alu_a=0, alu_b=0, alu_op=0; out_valid=0; out_result=0; out_taken=0; out_is_branch=0; out_illegal=0. Reset mid-EXEC or mid-DONE drops the operation with no response.
- States: IDLE, EXEC, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, on in_valid&in_ready:
  - Latch decode results into the operand and op registers.
  - Legal instruction -> EXEC with counter=ALU_WAIT-1.
  - Illegal instruction -> DONE with out_illegal=1, out_result=0, out_taken=0, alu_* held at 0.
- Decode, R-type (0110011):
  - B=rs2. funct3 000 ADD / SUB(funct7=0100000); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL / SRA(0100000); 110 OR; 111 AND.
  - funct7 other than 0000000 is illegal, except 0100000 with funct3 000/101.
- Decode, I-type ALU (0010011):
  - B=imm. funct3 000 always ADD; other funct3 values map as R-type.
  - Shifts (001, 101) use funct7 rules as R-type (0100000 legal only for 101); non-shift funct3 ignores funct7.
- Decode, Branch (1100011):
  - B=rs2, out_is_branch=1.
  - 000 BEQ: SUB, taken=zero. 001 BNE: SUB, taken=!zero.
  - 100 BLT: SLT, taken=result[0]. 101 BGE: SLT, taken=!result[0].
  - 110 BLTU: SLTU, taken=result[0]. 111 BGEU: SLTU, taken=!result[0].
  - funct3 010/011 illegal.
- Any other opcode is illegal.
- Operand A is always rs1.
- EXEC:
  - alu_a/alu_b/alu_op stable from the registers for exactly ALU_WAIT cycles.
  - On the cycle with counter==0: sample alu_result and alu_zero into out_result/out_taken, go to DONE. Otherwise decrement the counter.
- DONE: outputs held stable while out_valid=1 and out_ready=0. On out_ready=1 -> IDLE.
  - On the exit edge, clear alu_op/alu_a/alu_b to 0.
  - Response fields keep their last values; meaningful only while out_valid=1.
- Latency: accept edge T -> out_valid high from T+ALU_WAIT+1. Illegal: out_valid high from T+1.
- Throughput: no new accept in the same cycle as a response handshake. Minimum spacing between accepts is ALU_WAIT+2 cycles.
- in_valid while not in IDLE is ignored; the input fields must be held by the source.

Test Plan:
- R-type SUB: rs1=0x00000005, rs2=0x00000007, funct7=0100000, ALU_WAIT=1 -> alu_op=1 for one cycle; out_result=0xFFFFFFFE, out_taken=0, out_valid at T+2.
- BLT, rs1=0xFFFFFFFF (-1), rs2=1 -> alu_op=8; out_result=1, out_taken=1. Same operands as BLTU -> alu_op=9, out_taken=0.
- BEQ, rs1=rs2=0x1234 -> alu_op=1, out_taken=1. BNE with the same operands -> out_taken=0.
- SRAI, imm=0x404, funct7=0100000, rs1=0x80000000 -> alu_op=7, alu_b=0x404; out_result=0xF8000000. Then opcode 0x7F -> out_illegal=1, out_valid at T+1, alu_op stays 0.
- Backpressure with ALU_WAIT=3: hold out_ready=0 for 5 cycles -> out_valid and out_result stable, in_ready=0. Release -> in_ready=1 the next cycle.
- Assert rst_n=0 during EXEC -> next cycle state IDLE, out_valid=0, alu_op=0, no response ever emitted for that instruction.
